fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC register, next-PC selection, the instruction-memory request/response handshake and the IF/ID pipeline register. Sits directly upstream of the hazard detection unit and consumes its `stall_IF`, `flush_ID`, `NPCOp_out`, `NPCImm_out` and `base_PC_out`. Feeds `PC_ID` and `instr_ID` to decode. Tolerates variable-latency instruction memory with at most one request outstanding.

---
 rtl/fetch_unit_pkg.sv | 34 +++
 rtl/fetch_unit_npc_gen.sv | 35 +++
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   - NPC_* next-PC operation codes (same values as ctrl_encode_def.v)
//   - INSTR_NOP, the word shown in IF/ID when it holds no real instruction
//   - 2-bit fetch FSM state encoding
//   - ifid_t, the IF/ID pipeline register layout
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    // JALR targets always have bit 0 cleared.
    function automatic logic [31:0] jalr_target(input logic [31:0] alu_result);
        return alu_result & ~32'h1;
    endfunction

endpackage

// File: rtl/fetch_unit_npc_gen.sv
// -----------------------------------------------------------------------------
// npc_gen
// Combinational next-PC decode. Reports whether the presented NPC operation
// redirects the fetch stream and, if so, where to. Stall gating is left to the
// caller so this block stays a pure function of the hazard-unit outputs.
// Ports:
//   npc_op_i       next-PC operation (NPC_* code)
//   npc_imm_i      branch/JAL offset
//   base_pc_i      PC the offset is added to
//   alu_result_i   JALR target from EX
//   redirect_o     operation is anything other than PC+4
//   target_o       redirect destination
// -----------------------------------------------------------------------------
module npc_gen
    import fetch_unit_pkg::*;
(
    input  logic [2:0]  npc_op_i,
    input  logic [31:0] npc_imm_i,
    input  logic [31:0] base_pc_i,
    input  logic [31:0] alu_result_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    always_comb begin
        redirect_o = (npc_op_i != NPC_PLUS4);
        if (npc_op_i == NPC_JALR) begin
            target_o = jalr_target(alu_result_i);
        end else begin
            // Branch and JAL share the PC-relative adder; wraps mod 2^32.
            target_o = base_pc_i + npc_imm_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: PC register, next-PC selection, single-outstanding
// instruction-memory handshake, one-entry skid buffer and the IF/ID register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_IF, flush_ID       hazard-unit hold / squash of IF/ID
//   NPCOp, NPCImm, base_PC   next-PC operation and PC-relative operands
//   alu_result_EX            JALR target
//   imem_req/addr/ready      fetch request channel (addr is the PC register)
//   imem_rvalid/rdata        fetch response channel, in order
//   PC_ID, instr_ID, valid_ID  IF/ID contents handed to decode
//   fetch_busy               IF/ID took a bubble for lack of a response
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF,
    input  logic        flush_ID,
    input  logic [2:0]  NPCOp,
    input  logic [31:0] NPCImm,
    input  logic [31:0] base_PC,
    input  logic [31:0] alu_result_EX,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_ID,
    output logic [31:0] instr_ID,
    output logic        valid_ID,
    output logic        fetch_busy
);

    logic        npc_redirect;
    logic [31:0] npc_target;
    logic        redirect;

    npc_gen u_npc_gen (
        .npc_op_i     (NPCOp),
        .npc_imm_i    (NPCImm),
        .base_pc_i    (base_PC),
        .alu_result_i (alu_result_EX),
        .redirect_o   (npc_redirect),
        .target_o     (npc_target)
    );

    // A redirect presented under stall is ignored; the hazard unit repeats it.
    assign redirect = npc_redirect && !stall_IF;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] skid_q, skid_d;
    logic        rst_pend_q, rst_pend_d;
    ifid_t       ifid_q, ifid_d;
    logic        busy_q, busy_d;

    logic        req;
    logic        load_resp;
    logic        load_skid;
    logic        outstanding;

    // A request is still in flight if we are waiting for (or discarding) a
    // response that has not shown up this cycle. Reset records this so the
    // late response is not mistaken for the first post-reset fetch.
    assign outstanding = ((state_q == ST_WAIT) || (state_q == ST_DISCARD) || rst_pend_q)
                         && !imem_rvalid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        skid_d     = skid_q;
        rst_pend_d = rst_pend_q;
        req        = 1'b0;
        load_resp  = 1'b0;
        load_skid  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (rst_pend_q) begin
                    // Behaves like DISCARD until the pre-reset response drains.
                    if (imem_rvalid) begin
                        rst_pend_d = 1'b0;
                    end
                end else begin
                    req = !stall_IF && !redirect;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        state_d = ST_FETCH;
                    end else if (stall_IF) begin
                        // req_pc_q already names this word; only the data is parked.
                        skid_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        load_resp = 1'b1;
                        req       = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end else if (redirect) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = ST_FETCH;
                end else if (!stall_IF) begin
                    load_skid = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (req && imem_ready) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_WAIT;
        end

        if (redirect) begin
            pc_d = npc_target;
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        busy_d = busy_q;
        if (stall_IF) begin
            ifid_d = ifid_q;
        end else if (flush_ID) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = INSTR_NOP;
            busy_d       = 1'b0;
        end else if (load_resp) begin
            ifid_d.pc    = req_pc_q;
            ifid_d.instr = imem_rdata;
            ifid_d.valid = 1'b1;
            busy_d       = 1'b0;
        end else if (load_skid) begin
            ifid_d.pc    = req_pc_q;
            ifid_d.instr = skid_q;
            ifid_d.valid = 1'b1;
            busy_d       = 1'b0;
        end else begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = INSTR_NOP;
            busy_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            rst_pend_q <= outstanding;
            ifid_q.pc    <= 32'h0;
            ifid_q.instr <= INSTR_NOP;
            ifid_q.valid <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rst_pend_q <= rst_pend_d;
            ifid_q     <= ifid_d;
            busy_q     <= busy_d;
        end
    end

    // Issued-PC and skid data carry no meaning until their state uses them.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        skid_q   <= skid_d;
    end

    assign imem_req   = req && !rst;
    assign imem_addr  = pc_q;
    assign PC_ID      = ifid_q.pc;
    assign instr_ID   = ifid_q.instr;
    assign valid_ID   = ifid_q.valid;
    assign fetch_busy = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_IF;
    logic        flush_ID;
    logic [2:0]  NPCOp;
    logic [31:0] NPCImm;
    logic [31:0] base_PC;
    logic [31:0] alu_result_EX;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID;
    logic [31:0] instr_ID;
    logic        valid_ID;
    logic        fetch_busy;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_IF      (stall_IF),
        .flush_ID      (flush_ID),
        .NPCOp         (NPCOp),
        .NPCImm        (NPCImm),
        .base_PC       (base_PC),
        .alu_result_EX (alu_result_EX),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .PC_ID         (PC_ID),
        .instr_ID      (instr_ID),
        .valid_ID      (valid_ID),
        .fetch_busy    (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Memory model: one response per accepted request, after mem_lat cycles.
    logic        mem_pend = 1'b0;
    int          mem_due  = 0;
    logic [31:0] mem_addr_q = 32'h0;
    int          mem_lat  = 1;
    logic        rand_ready = 1'b0;
    logic        rand_lat   = 1'b0;
    logic        req_seen;
    logic        acc_seen;
    logic [31:0] acc_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A00_0003;
    endfunction

    function automatic logic [31:0] ref_target(input logic [2:0] op, input logic [31:0] imm,
                                               input logic [31:0] base, input logic [31:0] alu);
        if (op == NPC_JALR) return {alu[31:1], 1'b0};
        return base + imm;
    endfunction

    task automatic clear_ctrl();
        stall_IF      = 1'b0;
        flush_ID      = 1'b0;
        NPCOp         = NPC_PLUS4;
        NPCImm        = 32'h0;
        base_PC       = 32'h0;
        alu_result_EX = 32'h0;
    endtask

    task automatic tick();
        logic        acc;
        logic [31:0] a;
        imem_rvalid = mem_pend && (cyc == mem_due);
        imem_rdata  = imem_rvalid ? memf(mem_addr_q) : $urandom;
        imem_ready  = rand_ready ? ($urandom_range(0, 99) < 70) : 1'b1;
        #1;
        req_seen = imem_req;
        acc      = imem_req && imem_ready;
        a        = imem_addr;
        if (acc) begin
            total++;
            if (mem_pend && !imem_rvalid) begin
                bad++;
                $display("FAIL one_outstanding: request at %h issued while %h still pending", a, mem_addr_q);
            end
        end
        @(posedge clk);
        cyc++;
        if (imem_rvalid) mem_pend = 1'b0;
        if (acc) begin
            mem_pend   = 1'b1;
            mem_addr_q = a;
            mem_due    = cyc + (rand_lat ? int'($urandom_range(1, 3)) : mem_lat) - 1;
        end
        acc_seen = acc;
        acc_addr = a;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_ctrl();
        tick();
        for (int i = 0; i < 10 && mem_pend; i++) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ctrl();
        tick();
        tick();
        total++;
        if (PC_ID !== 32'h0 || instr_ID !== INSTR_NOP || valid_ID !== 1'b0 || fetch_busy !== 1'b0)
            begin bad++; $display("FAIL reset_ifid: pc=%h instr=%h v=%b busy=%b want 0/13/0/0", PC_ID, instr_ID, valid_ID, fetch_busy); end
        total++;
        if (imem_addr !== RST_PC || imem_req !== 1'b0)
            begin bad++; $display("FAIL reset_imem: addr=%h req=%b want %h/0", imem_addr, imem_req, RST_PC); end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        mem_lat = 1; rand_ready = 1'b0; rand_lat = 1'b0;
        do_reset();
        tick();
        total++;
        if (valid_ID !== 1'b0 || fetch_busy !== 1'b1 || imem_addr !== 32'h4)
            begin bad++; $display("FAIL first_bubble: v=%b busy=%b addr=%h want 0/1/4", valid_ID, fetch_busy, imem_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (valid_ID !== 1'b1 || PC_ID !== 32'(4 * i) || instr_ID !== memf(32'(4 * i)) || fetch_busy !== 1'b0)
                begin bad++; $display("FAIL stream_%0d: pc=%h instr=%h v=%b busy=%b want pc=%h", i, PC_ID, instr_ID, valid_ID, fetch_busy, 32'(4 * i)); end
        end
    endtask

    task automatic test_taken_branch();
        logic found;
        NPCOp = NPC_BRANCH; base_PC = 32'h40; NPCImm = 32'hFFFF_FFF0; flush_ID = 1'b1;
        tick();
        total++;
        if (req_seen !== 1'b0 || imem_addr !== 32'h30 || valid_ID !== 1'b0 || instr_ID !== INSTR_NOP)
            begin bad++; $display("FAIL branch_cycle: req=%b addr=%h v=%b instr=%h want 0/30/0/13", req_seen, imem_addr, valid_ID, instr_ID); end
        clear_ctrl();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (valid_ID) begin
                found = 1'b1;
                total++;
                if (PC_ID !== 32'h30 || instr_ID !== memf(32'h30))
                    begin bad++; $display("FAIL branch_target: pc=%h instr=%h want pc=30", PC_ID, instr_ID); end
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL branch_timeout: no valid instruction, want pc=30"); end
    endtask

    task automatic test_jalr_wait();
        logic found, first_acc;
        mem_lat = 3;
        do_reset();
        tick();
        NPCOp = NPC_JALR; alu_result_EX = 32'h101; flush_ID = 1'b1;
        tick();
        total++;
        if (imem_addr !== 32'h100 || req_seen !== 1'b0 || valid_ID !== 1'b0)
            begin bad++; $display("FAIL jalr_cycle: addr=%h req=%b v=%b want 100/0/0", imem_addr, req_seen, valid_ID); end
        clear_ctrl();
        found = 1'b0; first_acc = 1'b1;
        for (int i = 0; i < 15 && !found; i++) begin
            tick();
            if (acc_seen && first_acc) begin
                first_acc = 1'b0;
                total++;
                if (acc_addr !== 32'h100)
                    begin bad++; $display("FAIL jalr_req_addr: got %h want 00000100", acc_addr); end
            end
            if (valid_ID) begin
                found = 1'b1;
                total++;
                if (PC_ID !== 32'h100 || instr_ID !== memf(32'h100))
                    begin bad++; $display("FAIL jalr_first_valid: pc=%h instr=%h want pc=100", PC_ID, instr_ID); end
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL jalr_timeout: no valid instruction, want pc=100"); end
    endtask

    task automatic test_stall_skid();
        mem_lat = 1;
        do_reset();
        tick();
        tick();
        total++;
        if (valid_ID !== 1'b1 || PC_ID !== 32'h0)
            begin bad++; $display("FAIL skid_setup: pc=%h v=%b want 0/1", PC_ID, valid_ID); end
        mem_lat = 2;
        stall_IF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (req_seen !== 1'b0 || valid_ID !== 1'b1 || PC_ID !== 32'h0 || instr_ID !== memf(32'h0))
                begin bad++; $display("FAIL stall_hold_%0d: req=%b pc=%h instr=%h v=%b want 0/0/%h/1", i, req_seen, PC_ID, instr_ID, valid_ID, memf(32'h0)); end
        end
        stall_IF = 1'b0;
        tick();
        total++;
        if (req_seen !== 1'b0 || valid_ID !== 1'b1 || PC_ID !== 32'h4 || instr_ID !== memf(32'h4))
            begin bad++; $display("FAIL skid_release: req=%b pc=%h instr=%h v=%b want 0/4/%h/1", req_seen, PC_ID, instr_ID, valid_ID, memf(32'h4)); end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] a_before;
        logic        found;
        a_before = imem_addr;
        stall_IF = 1'b1; NPCOp = NPC_JUMP; base_PC = 32'h200; NPCImm = 32'h20;
        tick();
        total++;
        if (imem_addr !== a_before || req_seen !== 1'b0)
            begin bad++; $display("FAIL stalled_jump: addr=%h req=%b want %h/0", imem_addr, req_seen, a_before); end
        stall_IF = 1'b0; flush_ID = 1'b1;
        tick();
        total++;
        if (imem_addr !== 32'h220 || valid_ID !== 1'b0)
            begin bad++; $display("FAIL released_jump: addr=%h v=%b want 220/0", imem_addr, valid_ID); end
        clear_ctrl();
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            tick();
            if (valid_ID) begin
                found = 1'b1;
                total++;
                if (PC_ID !== 32'h220 || instr_ID !== memf(32'h220))
                    begin bad++; $display("FAIL jump_first_valid: pc=%h instr=%h want pc=220", PC_ID, instr_ID); end
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL jump_timeout: no valid instruction, want pc=220"); end
    endtask

    task automatic test_reset_mid_wait();
        logic found, first_acc;
        mem_lat = 1;
        do_reset();
        tick();
        tick();
        mem_lat = 4;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (PC_ID !== 32'h0 || valid_ID !== 1'b0 || instr_ID !== INSTR_NOP || imem_addr !== RST_PC)
            begin bad++; $display("FAIL midwait_reset: pc=%h v=%b instr=%h addr=%h want 0/0/13/%h", PC_ID, valid_ID, instr_ID, imem_addr, RST_PC); end
        rst = 1'b0;
        found = 1'b0; first_acc = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (acc_seen && first_acc) begin
                first_acc = 1'b0;
                total++;
                if (acc_addr !== RST_PC)
                    begin bad++; $display("FAIL midwait_req_addr: got %h want %h", acc_addr, RST_PC); end
            end
            if (valid_ID) begin
                found = 1'b1;
                total++;
                if (PC_ID !== RST_PC || instr_ID !== memf(RST_PC))
                    begin bad++; $display("FAIL midwait_first_valid: pc=%h instr=%h want pc=%h", PC_ID, instr_ID, RST_PC); end
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL midwait_timeout: no valid instruction, want pc=%h", RST_PC); end
    endtask

    // Architectural check: valid instructions must arrive in program order,
    // following each accepted redirect, whatever the stall/memory timing.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          deliveries;
        rand_ready = 1'b0; rand_lat = 1'b0; mem_lat = 1;
        do_reset();
        rand_ready = 1'b1; rand_lat = 1'b1;
        exp_pc = RST_PC;
        deliveries = 0;
        for (int n = 0; n < 3000; n++) begin
            logic        st, rd, v_b;
            logic [2:0]  op;
            logic [31:0] tgt, pc_b, in_b;
            st = ($urandom_range(0, 99) < 20);
            op = NPC_PLUS4;
            if ($urandom_range(0, 99) < 8) begin
                case ($urandom_range(0, 2))
                    0:       op = NPC_BRANCH;
                    1:       op = NPC_JUMP;
                    default: op = NPC_JALR;
                endcase
            end
            stall_IF      = st;
            NPCOp         = op;
            flush_ID      = (op != NPC_PLUS4);
            base_PC       = $urandom & 32'h0000_FFFC;
            NPCImm        = $urandom;
            alu_result_EX = $urandom;
            rd  = (op != NPC_PLUS4) && !st;
            tgt = ref_target(op, NPCImm, base_PC, alu_result_EX);
            pc_b = PC_ID; in_b = instr_ID; v_b = valid_ID;
            tick();
            total++;
            if (rd) begin
                if (imem_addr !== tgt || valid_ID !== 1'b0 || req_seen !== 1'b0)
                    begin bad++; $display("FAIL rnd_redirect: addr=%h v=%b req=%b want %h/0/0", imem_addr, valid_ID, req_seen, tgt); end
                exp_pc = tgt;
            end else if (st) begin
                if (PC_ID !== pc_b || instr_ID !== in_b || valid_ID !== v_b)
                    begin bad++; $display("FAIL rnd_stall_hold: pc=%h instr=%h v=%b want %h/%h/%b", PC_ID, instr_ID, valid_ID, pc_b, in_b, v_b); end
            end else if (valid_ID) begin
                deliveries++;
                if (PC_ID !== exp_pc || instr_ID !== memf(exp_pc)) begin
                    bad++;
                    $display("FAIL rnd_order: pc=%h instr=%h want pc=%h instr=%h", PC_ID, instr_ID, exp_pc, memf(exp_pc));
                    exp_pc = PC_ID;
                end
                exp_pc = exp_pc + 32'd4;
            end else begin
                if (instr_ID !== INSTR_NOP)
                    begin bad++; $display("FAIL rnd_bubble_nop: instr=%h want 00000013", instr_ID); end
            end
        end
        clear_ctrl();
        rand_ready = 1'b0; rand_lat = 1'b0;
        total++;
        if (deliveries < 100)
            begin bad++; $display("FAIL rnd_progress: %0d instructions delivered, want at least 100", deliveries); end
    endtask

    initial begin
        rst = 1'b1;
        clear_ctrl();
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_taken_branch();
        test_jalr_wait();
        test_stall_skid();
        test_stall_redirect();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
